sram_bit_req_ctrl: RTL and testbench
====================================

# sram_bit_req_ctrl

Request front-end for the generic single-port, bit-masked synchronous SRAM. It sits directly upstream of the SRAM macro and drives its `n_cs`, `n_we`, `n_oe`, `mask`, `ad` and `din` inputs from a valid/ready request port. It returns read data on a valid/ready response port and zero-fills the whole array after every reset. Consumers see a pipelined, back-pressurable memory port instead of raw SRAM strobes.

## Interface
- `DW`, 140, data/mask width (matches SRAM)
- `DD`, 1024, SRAM depth in words
- `AW`, 10, address width; `DD` <= 2^AW
- `clk`  in  1  posedge clock, shared with SRAM
- `reset`  in  1  asynchronous, active-high reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  request accepted on edge when `req_valid & req_ready`
- `req_we`  in  1  1 = write, 0 = read
- `req_addr`  in  AW  word address
- `req_mask`  in  DW  per-bit write mask; 1 = bit not written
- `req_wdata`  in  DW  write data
- `rsp_valid`  out  1  read data valid
- `rsp_ready`  in  1  response consumed on edge when `rsp_valid & rsp_ready`
- `rsp_rdata`  out  DW  read data
- `addr_err`  out  1  one-cycle pulse: out-of-range request accepted
- `init_done`  out  1  zero-fill complete
- `sram_n_cs`, `sram_n_we`, `sram_n_oe`  out  1  SRAM strobes, active low
- `sram_mask`  out  DW  SRAM mask
- `sram_ad`  out  AW  SRAM address
- `sram_din`  out  DW  SRAM write data
- `sram_dout`  in  DW  SRAM data out; changes only on edges where the SRAM is selected

## Operation
- **Reset values:**
  - `req_ready` = 0, `rsp_valid` = 0, `addr_err` = 0, `init_done` = 0
  - `sram_n_cs` = `sram_n_we` = `sram_n_oe` = 1
  - `sram_ad` = 0, `sram_din` = 0, `sram_mask` = all ones
  - `rsp_rdata` = 0, `err_rd` = 0
  - state = INIT, init counter = 0
- **State INIT:**
  - Each edge loads the issue registers with a write: `ad` = counter, `din` = 0, `mask` = 0.
  - The counter then increments.
  - After loading address DD-1, the next edge moves to RUN and sets `init_done`.
  - `req_ready` = 0 throughout INIT.
- **State RUN:**
  - `req_ready = ~stall`, where `stall = rsp_valid & ~rsp_ready`.
  - An accepted request loads the issue registers (`we`, `addr`, `mask`, `wdata`) and sets `iss_valid`.
  - With no accept, `iss_valid` clears, unless stalled, in which case all issue registers hold.
- **SRAM drive (all from registers except the stall gate):**
  - `sram_n_cs = ~iss_valid | stall | iss_oor`
  - `sram_n_we = ~iss_we`
  - `sram_n_oe = sram_n_cs`
- **Out-of-range handling (`addr` >= DD):**
  - `iss_oor` is set and the SRAM is not selected.
  - `addr_err` pulses for the cycle the request sits in issue.
  - A read still produces a response, with `rsp_rdata` = 0.
  - A write is dropped.
- **Response path:**
  - Edge issuing a read with no stall: sets `rsp_valid`; `err_rd` is loaded with `iss_oor`.
  - `rsp_rdata = err_rd ? 0 : sram_dout`. The SRAM holds `dout` while deselected, so the data is stable under stall.
  - `rsp_valid` clears on the edge where `rsp_ready` = 1, unless a new read issues on that same edge.
- **Other rules:**
  - Writes are posted and produce no response.
  - Order is strictly preserved. Read-after-write to the same address returns the new data because the SRAM is single-port and in order.
  - `reset` asserted mid-operation: an in-flight response is discarded, state returns to INIT, and the full zero-fill reruns.

## Timing
- **Init:** edge 1 after reset release loads address 0; the SRAM writes it at edge 2. The edge that performs the SRAM write of DD-1 (edge DD+1) also sets `init_done`, so `req_ready` rises at edge DD+1.
- **Read latency:** accept at edge k, SRAM access at edge k+1, `rsp_valid` high from edge k+1. With `rsp_ready` = 1 the data is consumed at edge k+2.
- **Throughput:** one request per cycle with `rsp_ready` held at 1.
- **Stall:** while `rsp_valid & ~rsp_ready`:
  - `req_ready` = 0
  - `sram_n_cs` = 1 in the same cycle
  - the issue stage and `rsp_rdata` are frozen
  - issue resumes on the edge where `rsp_ready` goes high.
- **Writes:** become visible to a read accepted on the very next edge.

## Test plan
- Release reset, DD=16 -> `init_done` rises at edge 17; back-to-back reads of all 16 addresses return 0, one per cycle.
- Write addr 5, data all ones, mask = 0x0…00FF, then read 5 -> bits [7:0] = 0, all other bits = 1.
- Read addr 3 with `rsp_ready` = 0 for 4 cycles while `req_valid` stays high for a read of addr 4:
  - `req_ready` = 0 and `sram_n_cs` = 1 for all 4 cycles
  - addr 3 data is returned first, then addr 4 data
- Write addr 7 = 0xA5 (mask 0), read addr 7 on the next cycle -> 0xA5 with 2-edge latency.
- DD=12, AW=4: read addr 13 -> `addr_err` one-cycle pulse, `rsp_rdata` = 0, SRAM never selected. Write addr 13 -> `addr_err` pulse, no SRAM write.
- Assert `reset` mid-stream with `rsp_valid` = 1 -> `rsp_valid` = 0 and `sram_n_cs` = 1 immediately; after release, init reruns and a prior write reads back 0.

Source files
------------

// File: rtl/sram_bit_req_ctrl_if.sv
// sram_bit_req_ctrl_if: request/response bundle in front of the bit-masked SRAM controller.
//   req_valid/req_ready/req_we/req_addr/req_mask/req_wdata : request channel (mask 1 = keep bit)
//   rsp_valid/rsp_ready/rsp_rdata                          : read response channel
// Modports: master = requester side, slave = controller side.
interface sram_bit_req_ctrl_if #(
  parameter int unsigned DW = 140,
  parameter int unsigned AW = 10
) ();
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_mask;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_mask, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_mask, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/sram_bit_req_ctrl.sv
// sram_bit_req_ctrl: pipelined valid/ready front-end for a single-port bit-masked SRAM.
// Zero-fills the whole array after every reset, then issues one request per cycle.
// Ports:
//   clk, reset     : clock shared with the SRAM, asynchronous active-high reset
//   bus (slave)    : request/response handshake bundle
//   addr_err       : one-cycle pulse when an out-of-range request enters issue
//   init_done      : zero-fill complete, requests accepted from here on
//   sram_n_cs/n_we/n_oe, sram_mask, sram_ad, sram_din : SRAM macro inputs
//   sram_dout      : SRAM read data (held by the macro while deselected)
module sram_bit_req_ctrl #(
  parameter int unsigned DW = 140,
  parameter int unsigned DD = 1024,
  parameter int unsigned AW = 10
) (
  input  logic                clk,
  input  logic                reset,
  sram_bit_req_ctrl_if.slave  bus,
  output logic                addr_err,
  output logic                init_done,
  output logic                sram_n_cs,
  output logic                sram_n_we,
  output logic                sram_n_oe,
  output logic [DW-1:0]       sram_mask,
  output logic [AW-1:0]       sram_ad,
  output logic [DW-1:0]       sram_din,
  input  logic [DW-1:0]       sram_dout
);

  // One extra bit so DD == 2**AW is representable.
  localparam logic [AW:0] DepthW = DD[AW:0];

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e        state_q;
  logic [AW:0]   init_cnt_q;
  logic          init_done_q;

  logic          iss_valid_q;
  logic          iss_we_q;
  logic          iss_oor_q;
  logic [AW-1:0] iss_addr_q;
  logic [DW-1:0] iss_mask_q;
  logic [DW-1:0] iss_wdata_q;

  logic          rsp_valid_q;
  logic          err_rd_q;
  logic          addr_err_q;

  logic          stall;
  logic          accept;
  logic          req_oor;

  // An unconsumed response blocks everything: the SRAM output register is the response buffer.
  assign stall         = rsp_valid_q & ~bus.rsp_ready;
  assign bus.req_ready = (state_q == StRun) & ~stall;
  assign accept        = bus.req_valid & bus.req_ready;
  assign req_oor       = {1'b0, bus.req_addr} >= DepthW;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StInit;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
      iss_valid_q <= 1'b0;
      iss_we_q    <= 1'b0;
      iss_oor_q   <= 1'b0;
      iss_addr_q  <= '0;
      iss_mask_q  <= '1;
      iss_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      err_rd_q    <= 1'b0;
      addr_err_q  <= 1'b0;
    end else begin
      addr_err_q <= 1'b0;

      case (state_q)
        StInit: begin
          if (init_cnt_q == DepthW) begin
            // Last zero-fill write is being performed on this edge.
            state_q     <= StRun;
            init_done_q <= 1'b1;
            iss_valid_q <= 1'b0;
            iss_we_q    <= 1'b0;
          end else begin
            iss_valid_q <= 1'b1;
            iss_we_q    <= 1'b1;
            iss_oor_q   <= 1'b0;
            iss_addr_q  <= init_cnt_q[AW-1:0];
            iss_mask_q  <= '0;
            iss_wdata_q <= '0;
            init_cnt_q  <= init_cnt_q + 1'b1;
          end
        end
        StRun: begin
          if (accept) begin
            iss_valid_q <= 1'b1;
            iss_we_q    <= bus.req_we;
            iss_oor_q   <= req_oor;
            iss_addr_q  <= bus.req_addr;
            iss_mask_q  <= bus.req_mask;
            iss_wdata_q <= bus.req_wdata;
            addr_err_q  <= req_oor;
          end else if (!stall) begin
            iss_valid_q <= 1'b0;
          end
        end
        default: state_q <= StInit;
      endcase

      // Response side: a read in issue completes on any non-stalled edge.
      if (!stall) begin
        if (iss_valid_q && !iss_we_q) begin
          rsp_valid_q <= 1'b1;
          err_rd_q    <= iss_oor_q;
        end else if (bus.rsp_ready) begin
          rsp_valid_q <= 1'b0;
        end
      end
    end
  end

  assign sram_n_cs = ~iss_valid_q | stall | iss_oor_q;
  assign sram_n_we = ~iss_we_q;
  assign sram_n_oe = sram_n_cs;
  assign sram_ad   = iss_addr_q;
  assign sram_din  = iss_wdata_q;
  assign sram_mask = iss_mask_q;

  assign bus.rsp_valid = rsp_valid_q;
  // Zero when no response is presented or the read was out of range.
  assign bus.rsp_rdata = (rsp_valid_q && !err_rd_q) ? sram_dout : '0;

  assign addr_err  = addr_err_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_sram_bit_req_ctrl.sv
module tb_sram_bit_req_ctrl;
  localparam int unsigned DW = 140;
  localparam int unsigned DD = 12;
  localparam int unsigned AW = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sram_bit_req_ctrl_if #(.DW(DW), .AW(AW)) bus ();

  logic          addr_err, init_done;
  logic          sram_n_cs, sram_n_we, sram_n_oe;
  logic [DW-1:0] sram_mask, sram_din, sram_dout;
  logic [AW-1:0] sram_ad;

  sram_bit_req_ctrl #(.DW(DW), .DD(DD), .AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .addr_err  (addr_err),
    .init_done (init_done),
    .sram_n_cs (sram_n_cs),
    .sram_n_we (sram_n_we),
    .sram_n_oe (sram_n_oe),
    .sram_mask (sram_mask),
    .sram_ad   (sram_ad),
    .sram_din  (sram_din),
    .sram_dout (sram_dout)
  );

  // Behavioural bit-masked SRAM macro; full 2**AW entries so stray accesses are visible.
  logic [DW-1:0] sram_mem [16];
  logic          scramble;
  always @(posedge clk) begin
    if (scramble) begin
      for (int i = 0; i < 16; i++) sram_mem[i] <= ~DW'(i * 3 + 1);
      sram_dout <= {35{4'h9}};
    end else if (!sram_n_cs) begin
      if (!sram_n_we)
        sram_mem[sram_ad] <= (sram_mem[sram_ad] & sram_mask) | (sram_din & ~sram_mask);
      else if (!sram_n_oe)
        sram_dout <= sram_mem[sram_ad];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // Reference memory and scoreboard of expected read data, in order.
  logic [DW-1:0] ref_mem [DD];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] mon_exp;

  task automatic ref_clear();
    for (int i = 0; i < int'(DD); i++) ref_mem[i] = '0;
  endtask

  task automatic do_req(input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] mask, input logic [DW-1:0] wdata);
    bit          done;
    int unsigned a;
    done          = 1'b0;
    a             = 32'(addr);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_mask  = mask;
    bus.req_wdata = wdata;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        @(posedge clk);
        if (we) begin
          if (a < DD) ref_mem[a] = (ref_mem[a] & mask) | (wdata & ~mask);
        end else begin
          exp_q.push_back(a < DD ? ref_mem[a] : '0);
        end
        done = 1'b1;
      end else begin
        @(posedge clk);
      end
    end
    check("req_accept", DW'(done), DW'(1));
    #1;
  endtask

  task automatic idle();
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(posedge clk);
    check("drain", DW'(exp_q.size()), DW'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic wait_init(output int edges);
    edges = 0;
    for (int i = 1; i <= 40 && edges == 0; i++) begin
      @(posedge clk);
      #1;
      if (init_done) edges = i;
    end
  endtask

  always @(negedge clk) begin
    if (!reset && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", DW'(bus.rsp_valid), DW'(0));
      end else begin
        mon_exp = exp_q.pop_front();
        check("rsp_data", bus.rsp_rdata, mon_exp);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  int edges, t0, t1;
  logic [DW-1:0] pre13;

  initial begin
    reset         = 1'b1;
    scramble      = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_mask  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;
    ref_clear();
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", DW'(bus.req_ready), DW'(0));
    check("rst_rsp_valid", DW'(bus.rsp_valid), DW'(0));
    check("rst_addr_err", DW'(addr_err), DW'(0));
    check("rst_init_done", DW'(init_done), DW'(0));
    check("rst_n_cs", DW'(sram_n_cs), DW'(1));
    check("rst_n_we", DW'(sram_n_we), DW'(1));
    check("rst_n_oe", DW'(sram_n_oe), DW'(1));
    check("rst_ad", DW'(sram_ad), DW'(0));
    check("rst_din", sram_din, DW'(0));
    check("rst_mask", sram_mask, {DW{1'b1}});
    check("rst_rdata", bus.rsp_rdata, DW'(0));

    @(negedge clk);
    reset    = 1'b0;
    scramble = 1'b0;
    wait_init(edges);
    check("init_edge", DW'(edges), DW'(DD + 1));
    check("ready_after_init", DW'(bus.req_ready), DW'(1));

    // Zero-fill: back-to-back reads of every address, one per cycle.
    t0 = cyc;
    for (int i = 0; i < int'(DD); i++) do_req(1'b0, AW'(i), '0, '0);
    t1 = cyc;
    idle();
    check("throughput", DW'(t1 - t0), DW'(DD));
    drain();

    // Masked write: low byte kept (stays 0), rest written to 1.
    do_req(1'b1, AW'(5), DW'(8'hFF), {DW{1'b1}});
    do_req(1'b0, AW'(5), '0, '0);
    idle();
    drain();

    // Back-pressure: read 3, read 4 accepted, read 5 held off while stalled.
    do_req(1'b1, AW'(3), '0, {35{4'h3}});
    do_req(1'b1, AW'(4), '0, {35{4'hC}});
    bus.rsp_ready = 1'b0;
    do_req(1'b0, AW'(3), '0, '0);
    do_req(1'b0, AW'(4), '0, '0);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = AW'(5);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_req_ready", DW'(bus.req_ready), DW'(0));
      check("stall_n_cs", DW'(sram_n_cs), DW'(1));
      check("stall_rdata", bus.rsp_rdata, {35{4'h3}});
    end
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    do_req(1'b0, AW'(5), '0, '0);
    idle();
    drain();

    // Read-after-write latency.
    do_req(1'b1, AW'(7), '0, DW'(8'hA5));
    do_req(1'b0, AW'(7), '0, '0);
    idle();
    @(negedge clk);
    check("lat_k_valid", DW'(bus.rsp_valid), DW'(0));
    @(negedge clk);
    check("lat_k1_valid", DW'(bus.rsp_valid), DW'(1));
    check("lat_k1_data", bus.rsp_rdata, DW'(8'hA5));
    drain();

    // Out-of-range read.
    do_req(1'b0, AW'(13), '0, '0);
    check("oor_rd_err", DW'(addr_err), DW'(1));
    check("oor_rd_n_cs", DW'(sram_n_cs), DW'(1));
    idle();
    @(posedge clk);
    #1;
    check("oor_rd_err_pulse", DW'(addr_err), DW'(0));
    drain();

    // Out-of-range write.
    pre13 = sram_mem[13];
    do_req(1'b1, AW'(13), '0, {DW{1'b1}});
    check("oor_wr_err", DW'(addr_err), DW'(1));
    check("oor_wr_n_cs", DW'(sram_n_cs), DW'(1));
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("oor_wr_err_pulse", DW'(addr_err), DW'(0));
    check("oor_wr_mem", sram_mem[13], pre13);

    // Reset with a response outstanding; zero-fill must rerun.
    do_req(1'b1, AW'(2), '0, DW'(16'h1234));
    bus.rsp_ready = 1'b0;
    do_req(1'b0, AW'(2), '0, '0);
    idle();
    @(posedge clk);
    #1;
    check("pre_rst_valid", DW'(bus.rsp_valid), DW'(1));
    check("pre_rst_data", bus.rsp_rdata, DW'(16'h1234));
    reset = 1'b1;
    #1;
    check("mid_rst_valid", DW'(bus.rsp_valid), DW'(0));
    check("mid_rst_n_cs", DW'(sram_n_cs), DW'(1));
    check("mid_rst_init_done", DW'(init_done), DW'(0));
    exp_q.delete();
    ref_clear();
    bus.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    wait_init(edges);
    check("reinit_edge", DW'(edges), DW'(DD + 1));
    do_req(1'b0, AW'(2), '0, '0);
    idle();
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
